// File: rtl/gh18b20_sched.sv
// gh18b20 1-wire bus master: skip-ROM, convert, wait, read scratchpad, CRC check, retry.
module gh18b20_sched #(
    parameter int unsigned CLK_PER_US   = 50,
    parameter int unsigned CONV_WAIT_US = 750000,
    parameter int unsigned AUTO_GAP_US  = 100000,
    parameter int unsigned RETRY_MAX    = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        auto_en,
    inout  wire         dq,
    output logic        busy,
    output logic [15:0] temp_data,
    output logic        temp_valid,
    output logic        err_no_pres,
    output logic        err_crc
);

    localparam int unsigned PRE_W      = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int unsigned US_MAX0    = (CONV_WAIT_US > AUTO_GAP_US) ? CONV_WAIT_US : AUTO_GAP_US;
    localparam int unsigned US_MAX     = (US_MAX0 > 500) ? US_MAX0 : 500;
    localparam int unsigned US_W       = $clog2(US_MAX + 1);
    localparam int unsigned T_RST_LOW  = 500;
    localparam int unsigned T_PRES_SMP = 70;
    localparam int unsigned T_RST_WAIT = 480;
    localparam int unsigned T_SLOT     = 65;
    localparam int unsigned T_W1_LOW   = 2;
    localparam int unsigned T_W0_LOW   = 60;
    localparam int unsigned T_RD_LOW   = 2;
    localparam int unsigned T_RD_SMP   = 12;

    typedef enum logic [3:0] {
        S_IDLE, S_RST_LOW, S_RST_WAIT, S_WR_CC, S_WR_44, S_WR_BE, S_CONV_WAIT,
        S_RD_9, S_CHECK, S_RETRY, S_DONE, S_ERR, S_IDLE_GAP
    } state_e;

    state_e            state_q, state_d;
    logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [US_W-1:0]   us_cnt_q, us_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic              pass_q, pass_d;
    logic [2:0]        retry_q, retry_d;
    logic              pres_q, pres_d;
    logic              cause_np_q, cause_np_d;
    logic [7:0]        rx_q, rx_d;
    logic [7:0]        crc_q, crc_d;
    logic [7:0]        lsb_q, lsb_d;
    logic [7:0]        msb_q, msb_d;
    logic              dq_oe_q, dq_oe_d;
    logic              dq_meta_q, dq_meta_d;
    logic              dq_sync_q, dq_sync_d;
    logic              busy_q, busy_d;
    logic [15:0]       temp_data_q, temp_data_d;
    logic              temp_valid_q, temp_valid_d;
    logic              err_no_pres_q, err_no_pres_d;
    logic              err_crc_q, err_crc_d;
    logic              us_tick;
    logic              slot_end;
    logic              launch;
    logic              crc_fb;
    logic [7:0]        cmd;

    // Open-drain drive: only ever pull low.
    assign dq          = dq_oe_q ? 1'b0 : 1'bz;
    assign busy        = busy_q;
    assign temp_data   = temp_data_q;
    assign temp_valid  = temp_valid_q;
    assign err_no_pres = err_no_pres_q;
    assign err_crc     = err_crc_q;

    // Free-running 1 us prescaler and two-flop synchronizer on the line.
    always_comb begin
        us_tick   = 1'b0;
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
        if (pre_cnt_q == PRE_W'(CLK_PER_US - 1)) begin
            pre_cnt_d = '0;
            us_tick   = 1'b1;
        end
        dq_meta_d = dq;
        dq_sync_d = dq_meta_q;
    end

    // Next-state, counters, receive datapath and registered outputs.
    always_comb begin
        state_d       = state_q;
        us_cnt_d      = us_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        pass_d        = pass_q;
        retry_d       = retry_q;
        pres_d        = pres_q;
        cause_np_d    = cause_np_q;
        rx_d          = rx_q;
        crc_d         = crc_q;
        lsb_d         = lsb_q;
        msb_d         = msb_q;
        busy_d        = busy_q;
        temp_data_d   = temp_data_q;
        temp_valid_d  = 1'b0;
        err_no_pres_d = err_no_pres_q;
        err_crc_d     = err_crc_q;
        launch        = 1'b0;
        crc_fb        = crc_q[0] ^ dq_sync_q;
        slot_end      = us_tick && (us_cnt_q == US_W'(T_SLOT - 1));

        case (state_q)
            S_IDLE: begin
                if (start) launch = 1'b1;
            end
            S_IDLE_GAP: begin
                if (start || (us_tick && us_cnt_q == US_W'(AUTO_GAP_US - 1))) begin
                    launch = 1'b1;
                end else if (!auto_en) begin
                    state_d = S_IDLE;
                end else if (us_tick) begin
                    us_cnt_d = us_cnt_q + US_W'(1);
                end
            end
            S_RST_LOW: begin
                if (us_tick) begin
                    us_cnt_d = us_cnt_q + US_W'(1);
                    if (us_cnt_q == US_W'(T_RST_LOW - 1)) begin
                        us_cnt_d = '0;
                        state_d  = S_RST_WAIT;
                    end
                end
            end
            S_RST_WAIT: begin
                if (us_tick) begin
                    us_cnt_d = us_cnt_q + US_W'(1);
                    if (us_cnt_q == US_W'(T_PRES_SMP)) pres_d = ~dq_sync_q;
                    if (us_cnt_q == US_W'(T_RST_WAIT - 1)) begin
                        us_cnt_d  = '0;
                        bit_cnt_d = '0;
                        if (pres_q) begin
                            state_d = S_WR_CC;
                        end else begin
                            cause_np_d = 1'b1;
                            state_d    = S_RETRY;
                        end
                    end
                end
            end
            S_WR_CC, S_WR_44, S_WR_BE: begin
                if (us_tick) us_cnt_d = us_cnt_q + US_W'(1);
                if (slot_end) begin
                    us_cnt_d  = '0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        case (state_q)
                            S_WR_CC: state_d = pass_q ? S_WR_BE : S_WR_44;
                            S_WR_44: state_d = S_CONV_WAIT;
                            default: begin
                                state_d    = S_RD_9;
                                byte_cnt_d = '0;
                                crc_d      = '0;
                            end
                        endcase
                    end
                end
            end
            S_CONV_WAIT: begin
                if (us_tick) begin
                    us_cnt_d = us_cnt_q + US_W'(1);
                    if (us_cnt_q == US_W'(CONV_WAIT_US - 1)) begin
                        us_cnt_d = '0;
                        pass_d   = 1'b1;
                        state_d  = S_RST_LOW;
                    end
                end
            end
            S_RD_9: begin
                if (us_tick) us_cnt_d = us_cnt_q + US_W'(1);
                if (us_tick && us_cnt_q == US_W'(T_RD_SMP)) begin
                    rx_d  = {dq_sync_q, rx_q[7:1]};
                    crc_d = {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
                end
                if (slot_end) begin
                    us_cnt_d  = '0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q == 4'd0) lsb_d = rx_q;
                        if (byte_cnt_q == 4'd1) msb_d = rx_q;
                        if (byte_cnt_q == 4'd8) state_d = S_CHECK;
                        else                    byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            S_CHECK: begin
                if (crc_q == 8'h00) begin
                    temp_data_d  = {msb_q, lsb_q};
                    temp_valid_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    cause_np_d = 1'b0;
                    state_d    = S_RETRY;
                end
            end
            S_RETRY: begin
                if (retry_q < 3'(RETRY_MAX)) begin
                    retry_d  = retry_q + 3'd1;
                    pass_d   = 1'b0;
                    us_cnt_d = '0;
                    state_d  = S_RST_LOW;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (state_q == S_ERR) begin
                    err_no_pres_d = cause_np_q;
                    err_crc_d     = ~cause_np_q;
                end
                busy_d   = 1'b0;
                us_cnt_d = '0;
                state_d  = auto_en ? S_IDLE_GAP : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Accepted start (manual or auto) begins a fresh transaction.
        if (launch) begin
            state_d       = S_RST_LOW;
            us_cnt_d      = '0;
            pass_d        = 1'b0;
            retry_d       = '0;
            err_no_pres_d = 1'b0;
            err_crc_d     = 1'b0;
            busy_d        = 1'b1;
        end
    end

    // Line drive follows the phase being entered so dq and state change together.
    always_comb begin
        dq_oe_d = 1'b0;
        case (state_d)
            S_WR_CC: cmd = 8'hCC;
            S_WR_44: cmd = 8'h44;
            S_WR_BE: cmd = 8'hBE;
            default: cmd = 8'h00;
        endcase
        case (state_d)
            S_RST_LOW:                 dq_oe_d = 1'b1;
            S_WR_CC, S_WR_44, S_WR_BE: dq_oe_d = us_cnt_d < (cmd[bit_cnt_d] ? US_W'(T_W1_LOW) : US_W'(T_W0_LOW));
            S_RD_9:                    dq_oe_d = us_cnt_d < US_W'(T_RD_LOW);
            default:                   dq_oe_d = 1'b0;
        endcase
    end

    // State and datapath registers; reset releases the line immediately.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            pre_cnt_q     <= '0;
            us_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            pass_q        <= 1'b0;
            retry_q       <= '0;
            pres_q        <= 1'b0;
            cause_np_q    <= 1'b0;
            rx_q          <= '0;
            crc_q         <= '0;
            lsb_q         <= '0;
            msb_q         <= '0;
            dq_oe_q       <= 1'b0;
            dq_meta_q     <= 1'b1;
            dq_sync_q     <= 1'b1;
            busy_q        <= 1'b0;
            temp_data_q   <= 16'h07D0;
            temp_valid_q  <= 1'b0;
            err_no_pres_q <= 1'b0;
            err_crc_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_cnt_q     <= pre_cnt_d;
            us_cnt_q      <= us_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            pass_q        <= pass_d;
            retry_q       <= retry_d;
            pres_q        <= pres_d;
            cause_np_q    <= cause_np_d;
            rx_q          <= rx_d;
            crc_q         <= crc_d;
            lsb_q         <= lsb_d;
            msb_q         <= msb_d;
            dq_oe_q       <= dq_oe_d;
            dq_meta_q     <= dq_meta_d;
            dq_sync_q     <= dq_sync_d;
            busy_q        <= busy_d;
            temp_data_q   <= temp_data_d;
            temp_valid_q  <= temp_valid_d;
            err_no_pres_q <= err_no_pres_d;
            err_crc_q     <= err_crc_d;
        end
    end

endmodule

// File: tb/tb_gh18b20_sched.sv
// Bench for gh18b20_sched: behavioural 1-wire sensor model plus directed/random transactions.
`timescale 1ns/1ps
module tb_gh18b20_sched;

    localparam int unsigned CLK_PER_US   = 1;
    localparam int unsigned CONV_WAIT_US = 200;
    localparam int unsigned AUTO_GAP_US  = 500;
    localparam int unsigned RETRY_MAX    = 3;
    localparam int          US_T         = 10;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic        busy;
    logic [15:0] temp_data;
    logic        temp_valid;
    logic        err_no_pres;
    logic        err_crc;
    logic        slave_drv = 1'b0;
    wire         dq;

    assign dq = slave_drv ? 1'b0 : 1'bz;
    pullup (dq);

    always #5 clk = ~clk;

    gh18b20_sched #(
        .CLK_PER_US  (CLK_PER_US),
        .CONV_WAIT_US(CONV_WAIT_US),
        .AUTO_GAP_US (AUTO_GAP_US),
        .RETRY_MAX   (RETRY_MAX)
    ) dut (
        .sys_clk    (clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .auto_en    (auto_en),
        .dq         (dq),
        .busy       (busy),
        .temp_data  (temp_data),
        .temp_valid (temp_valid),
        .err_no_pres(err_no_pres),
        .err_crc    (err_crc)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sensor model state
    bit          slave_present = 1'b1;
    bit          corrupt_pending = 1'b0;
    int          rst_cnt = 0;
    int          wr_slots = 0;
    int          rd_slots = 0;
    int          rst_len_us = 0;
    int          conv_gap_us = 0;
    bit          conv_ref_valid = 1'b0;
    time         t_conv_ref = 0;
    logic [7:0]  wr_q[$];
    logic [71:0] sp_q[$];
    logic [71:0] last_sp = '0;
    logic [15:0] exp_q[$];
    int          valid_cnt = 0;
    time         t_valid[$];

    // Scratchpad image: 8 data bytes followed by their Dallas CRC-8.
    function automatic logic [71:0] make_sp(input logic [7:0] lsb, input logic [7:0] msb);
        logic [63:0] body;
        logic [7:0]  c;
        logic        fb;
        body = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, msb, lsb};
        c = 8'h00;
        for (int i = 0; i < 64; i++) begin
            fb = c[0] ^ body[i];
            c  = c >> 1;
            if (fb) c = c ^ 8'h8C;
        end
        return {c, body};
    endfunction

    function automatic logic [31:0] cmd_word();
        logic [31:0] w = '0;
        for (int i = 0; i < wr_q.size() && i < 4; i++) w = {w[23:0], wr_q[i]};
        return w;
    endfunction

    // Behavioural sensor: classifies master low pulses by width, answers presence and reads.
    initial begin : sensor
        time         t0;
        int          d;
        int          bitpos;
        int          nbyte;
        int          txpos;
        bit          tx;
        logic [7:0]  sh;
        logic [71:0] txbits;
        bitpos = 0; nbyte = 0; txpos = 0; tx = 1'b0; sh = '0; txbits = '0;
        forever begin
            @(negedge dq);
            t0 = $time;
            if (tx) begin
                rd_slots++;
                if (!txbits[txpos]) begin
                    slave_drv = 1'b1;
                    #(30 * US_T);
                    slave_drv = 1'b0;
                end
                txpos++;
                if (txpos == 72) tx = 1'b0;
            end else begin
                @(posedge dq);
                d = int'(($time - t0) / US_T);
                if (d >= 400) begin
                    rst_cnt++;
                    rst_len_us = d;
                    if (conv_ref_valid) begin
                        conv_gap_us    = int'((t0 - t_conv_ref) / US_T);
                        conv_ref_valid = 1'b0;
                    end
                    bitpos = 0; nbyte = 0; sh = '0;
                    if (slave_present) begin
                        #(15 * US_T);
                        slave_drv = 1'b1;
                        #(120 * US_T);
                        slave_drv = 1'b0;
                    end
                end else begin
                    wr_slots++;
                    sh = {(d < 15), sh[7:1]};
                    bitpos++;
                    if (bitpos == 8) begin
                        bitpos = 0;
                        wr_q.push_back(sh);
                        if (nbyte == 1 && sh == 8'h44) begin
                            t_conv_ref     = t0;
                            conv_ref_valid = 1'b1;
                        end
                        if (nbyte == 1 && sh == 8'hBE && slave_present) begin
                            if (sp_q.size() > 0) last_sp = sp_q[0];
                            txbits = last_sp;
                            if (corrupt_pending) begin
                                txbits[71:64] = txbits[71:64] ^ 8'hFF;
                                corrupt_pending = 1'b0;
                            end else if (sp_q.size() > 0) begin
                                void'(sp_q.pop_front());
                            end
                            tx = 1'b1;
                            txpos = 0;
                        end
                        nbyte++;
                    end
                end
            end
        end
    end

    // Every temp_valid pulse must match the next expected reading.
    always @(negedge clk) begin
        if (sys_rst_n && temp_valid === 1'b1) begin
            valid_cnt++;
            t_valid.push_back($time);
            check("valid_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("temp_data", temp_data, exp_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic clear_model();
        rst_cnt = 0; wr_slots = 0; rd_slots = 0;
        wr_q.delete();
    endtask

    initial begin : main
        int          v0;
        int          n;
        logic [15:0] e;
        time         p1, p2;

        tick(5);
        check("rst_busy", busy, 0);
        check("rst_temp_data", temp_data, 16'h07D0);
        check("rst_temp_valid", temp_valid, 0);
        check("rst_err_no_pres", err_no_pres, 0);
        check("rst_err_crc", err_crc, 0);
        check("rst_dq", dq, 1);
        sys_rst_n = 1'b1;
        tick(5);

        // Silent bus: four attempts, no writes, presence error.
        slave_present = 1'b0;
        clear_model();
        pulse_start();
        check("np_busy", busy, 1);
        wait_idle("np_done", 8000);
        check("np_resets", rst_cnt, 4);
        check("np_wr_slots", wr_slots, 0);
        check("np_err_no_pres", err_no_pres, 1);
        check("np_err_crc", err_crc, 0);
        check("np_temp_hold", temp_data, 16'h07D0);
        check("np_valid_cnt", valid_cnt, 0);
        slave_present = 1'b1;

        // Nominal transaction with a start ignored while busy.
        clear_model();
        sp_q.push_back(make_sp(8'h91, 8'h01));
        exp_q.push_back(16'h0191);
        v0 = valid_cnt;
        pulse_start();
        check("nrm_err_cleared", err_no_pres, 0);
        tick(3000);
        pulse_start();
        wait_idle("nrm_done", 12000);
        check("nrm_resets", rst_cnt, 2);
        check("nrm_cmd_bytes", cmd_word(), 32'hCC44CCBE);
        check("nrm_wr_slots", wr_slots, 32);
        check("nrm_rd_slots", rd_slots, 72);
        check("nrm_valid_once", valid_cnt - v0, 1);
        check("nrm_temp_data", temp_data, 16'h0191);
        check("nrm_err_no_pres", err_no_pres, 0);
        check("nrm_err_crc", err_crc, 0);
        check("nrm_rst_len", 32'(rst_len_us >= 498 && rst_len_us <= 502), 1);
        check("nrm_conv_gap", 32'(conv_gap_us >= 63 + int'(CONV_WAIT_US) && conv_gap_us <= 67 + int'(CONV_WAIT_US)), 1);

        // Corrupted CRC on the first read only: one retry then success.
        clear_model();
        e = 16'($urandom);
        sp_q.push_back(make_sp(e[7:0], e[15:8]));
        exp_q.push_back(e);
        corrupt_pending = 1'b1;
        v0 = valid_cnt;
        pulse_start();
        wait_idle("crc_done", 22000);
        check("crc_resets", rst_cnt, 4);
        check("crc_rd_slots", rd_slots, 144);
        check("crc_wr_bytes", wr_q.size(), 8);
        check("crc_cmd_bytes", cmd_word(), 32'hCC44CCBE);
        check("crc_valid_once", valid_cnt - v0, 1);
        check("crc_temp_data", temp_data, e);
        check("crc_err_crc", err_crc, 0);
        check("crc_err_no_pres", err_no_pres, 0);

        // Free-running mode: negative reading first, then random readings.
        clear_model();
        sp_q.push_back(make_sp(8'h5E, 8'hFF));
        exp_q.push_back(16'hFF5E);
        for (int i = 0; i < 2; i++) begin
            e = 16'($urandom);
            sp_q.push_back(make_sp(e[7:0], e[15:8]));
            exp_q.push_back(e);
        end
        v0 = valid_cnt;
        auto_en = 1'b1;
        pulse_start();
        n = 0;
        while (valid_cnt < v0 + 3 && n < 32000) begin
            tick(1);
            n++;
        end
        check("auto_pulses", valid_cnt - v0, 3);
        p1 = 0; p2 = 1;
        if (t_valid.size() >= 3) begin
            p1 = t_valid[t_valid.size() - 2] - t_valid[t_valid.size() - 3];
            p2 = t_valid[t_valid.size() - 1] - t_valid[t_valid.size() - 2];
        end
        check("auto_period", 32'(p2), 32'(p1));
        tick(100);
        check("auto_gap_busy", busy, 0);
        auto_en = 1'b0;
        tick(3000);
        check("auto_stop_pulses", valid_cnt - v0, 3);
        check("auto_stop_busy", busy, 0);
        check("auto_exp_drained", exp_q.size(), 0);

        // Reset asserted during the first 0x44 slot (a zero bit) releases the line.
        clear_model();
        e = 16'($urandom);
        sp_q.push_back(make_sp(e[7:0], e[15:8]));
        exp_q.push_back(e);
        pulse_start();
        n = 0;
        while (wr_q.size() < 1 && n < 3000) begin
            tick(1);
            n++;
        end
        check("rst_cc_seen", 32'(wr_q.size() >= 1), 1);
        n = 0;
        while (dq !== 1'b0 && n < 200) begin
            tick(1);
            n++;
        end
        tick(20);
        check("rst_w44_low", dq, 0);
        sys_rst_n = 1'b0;
        #1;
        check("rst_mid_dq", dq, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_temp", temp_data, 16'h07D0);
        check("rst_mid_valid", temp_valid, 0);
        check("rst_mid_err", {err_no_pres, err_crc}, 0);
        tick(10);
        sys_rst_n = 1'b1;
        tick(10);
        clear_model();
        v0 = valid_cnt;
        pulse_start();
        wait_idle("post_rst_done", 12000);
        check("post_rst_resets", rst_cnt, 2);
        check("post_rst_cmd_bytes", cmd_word(), 32'hCC44CCBE);
        check("post_rst_rd_slots", rd_slots, 72);
        check("post_rst_valid", valid_cnt - v0, 1);
        check("post_rst_temp", temp_data, e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
